// File: rtl/ahb_lite_arbiter_2m_if.sv
// rtl/ahb_lite_arbiter_2m_if.sv - AHB-Lite port bundle shared by the arbiter master and slave sides
interface ahb_lite_arbiter_2m_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hsel;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hsel, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_arbiter_2m.sv
// rtl/ahb_lite_arbiter_2m.sv - two-master AHB-Lite arbiter with per-master holding registers
module ahb_lite_arbiter_2m #(
  parameter bit PRIORITY_FIXED = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_arbiter_2m_if.slave  m0,
  ahb_lite_arbiter_2m_if.slave  m1,
  ahb_lite_arbiter_2m_if.master s
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t      downer, downer_nxt;
  logic        pend0, pend1;
  logic [31:0] hold_addr0, hold_addr1;
  logic        hold_write0, hold_write1;
  logic [2:0]  hold_size0, hold_size1;
  logic        last_grant;
  logic        lock, lock_grant;

  logic        ready0, ready1;
  logic        req0, req1;
  logic        gnt_valid, gnt;
  logic        issue;
  logic        cap0, cap1;
  logic        unused_inputs;

  assign unused_inputs = ^{m0.hburst, m1.hburst, m0.htrans[0], m1.htrans[0]};

  // A pending request counts even though its master has since gone idle.
  assign req0 = pend0 | (m0.htrans[1] & ready0);
  assign req1 = pend1 | (m1.htrans[1] & ready1);

  always_comb begin
    gnt_valid = lock | req0 | req1;
    gnt       = 1'b0;
    if (lock)
      gnt = lock_grant;
    else if (req0 && req1)
      gnt = PRIORITY_FIXED ? 1'b0 : ~last_grant;
    else
      gnt = req1;
  end

  assign issue = gnt_valid & s.hready;
  assign cap0  = m0.htrans[1] & ready0 & ~(issue & ~gnt & ~pend0);
  assign cap1  = m1.htrans[1] & ready1 & ~(issue &  gnt & ~pend1);

  always_comb begin
    s.haddr  = 32'd0;
    s.hwrite = 1'b0;
    s.hsize  = 3'd0;
    if (!gnt) begin
      s.haddr  = pend0 ? hold_addr0  : m0.haddr;
      s.hwrite = pend0 ? hold_write0 : m0.hwrite;
      s.hsize  = pend0 ? hold_size0  : m0.hsize;
    end else begin
      s.haddr  = pend1 ? hold_addr1  : m1.haddr;
      s.hwrite = pend1 ? hold_write1 : m1.hwrite;
      s.hsize  = pend1 ? hold_size1  : m1.hsize;
    end
  end

  assign s.htrans = gnt_valid ? 2'b10 : 2'b00;
  assign s.hsel   = gnt_valid;
  assign s.hburst = 3'b000;

  always_ff @(posedge HCLK) begin
    if (HRESET)
      downer <= OWN_NONE;
    else
      downer <= downer_nxt;
  end

  always_comb begin
    downer_nxt = downer;
    if (s.hready)
      downer_nxt = gnt_valid ? (gnt ? OWN_M1 : OWN_M0) : OWN_NONE;
  end

  always_comb begin
    ready0 = 1'b1;
    ready1 = 1'b1;
    if (downer == OWN_M0)
      ready0 = s.hready;
    else if (pend0)
      ready0 = 1'b0;
    if (downer == OWN_M1)
      ready1 = s.hready;
    else if (pend1)
      ready1 = 1'b0;
  end

  assign m0.hready = ready0;
  assign m1.hready = ready1;
  assign m0.hresp  = (downer == OWN_M0) & s.hresp;
  assign m1.hresp  = (downer == OWN_M1) & s.hresp;
  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;
  assign s.hwdata  = (downer == OWN_M0) ? m0.hwdata :
                     (downer == OWN_M1) ? m1.hwdata : 32'd0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      hold_addr0  <= 32'd0;
      hold_addr1  <= 32'd0;
      hold_write0 <= 1'b0;
      hold_write1 <= 1'b0;
      hold_size0  <= 3'd0;
      hold_size1  <= 3'd0;
      last_grant  <= 1'b1;
      lock        <= 1'b0;
      lock_grant  <= 1'b0;
    end else begin
      if (issue) begin
        last_grant <= gnt;
        if (!gnt)
          pend0 <= 1'b0;
        else
          pend1 <= 1'b0;
      end
      if (cap0) begin
        pend0       <= 1'b1;
        hold_addr0  <= m0.haddr;
        hold_write0 <= m0.hwrite;
        hold_size0  <= m0.hsize;
      end
      if (cap1) begin
        pend1       <= 1'b1;
        hold_addr1  <= m1.haddr;
        hold_write1 <= m1.hwrite;
        hold_size1  <= m1.hsize;
      end
      // Freeze the slave-side address phase across wait states.
      if (s.hready)
        lock <= 1'b0;
      else if (gnt_valid && !lock) begin
        lock       <= 1'b1;
        lock_grant <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// tb/tb_ahb_lite_arbiter_2m.sv - scoreboard bench for the two-master AHB-Lite arbiter
module tb_ahb_lite_arbiter_2m;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
  } exp_t;

  logic HCLK;
  logic HRESET;
  int   n_checks;
  int   n_errors;
  exp_t rr_q[$];
  exp_t fx_q[$];

  ahb_lite_arbiter_2m_if m0_if ();
  ahb_lite_arbiter_2m_if m1_if ();
  ahb_lite_arbiter_2m_if s_if ();
  ahb_lite_arbiter_2m_if f0_if ();
  ahb_lite_arbiter_2m_if f1_if ();
  ahb_lite_arbiter_2m_if fs_if ();

  ahb_lite_arbiter_2m #(.PRIORITY_FIXED(1'b0)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  ahb_lite_arbiter_2m #(.PRIORITY_FIXED(1'b1)) dut_fx (
    .HCLK(HCLK), .HRESET(HRESET), .m0(f0_if), .m1(f1_if), .s(fs_if)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic drv_m0(input logic [1:0] t, input logic [31:0] a, input logic w);
    m0_if.htrans = t; m0_if.haddr = a; m0_if.hwrite = w;
  endtask

  task automatic drv_m1(input logic [1:0] t, input logic [31:0] a, input logic w);
    m1_if.htrans = t; m1_if.haddr = a; m1_if.hwrite = w;
  endtask

  task automatic drv_f0(input logic [1:0] t, input logic [31:0] a);
    f0_if.htrans = t; f0_if.haddr = a; f0_if.hwrite = 1'b0;
  endtask

  task automatic drv_f1(input logic [1:0] t, input logic [31:0] a);
    f1_if.htrans = t; f1_if.haddr = a; f1_if.hwrite = 1'b0;
  endtask

  // Every slave-side address phase accepted by S_HREADY must match the next expected transfer.
  always @(negedge HCLK) begin : rr_monitor
    exp_t e;
    if (!HRESET && s_if.htrans == 2'b10 && s_if.hready) begin
      if (rr_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rr_unexpected_issue: got addr 0x%08h expected no transfer", s_if.haddr);
      end else begin
        e = rr_q.pop_front();
        chk("rr_issue_addr", s_if.haddr, e.addr);
        chk("rr_issue_write", {31'd0, s_if.hwrite}, {31'd0, e.write});
      end
    end
  end

  always @(negedge HCLK) begin : fx_monitor
    exp_t e;
    if (!HRESET && fs_if.htrans == 2'b10 && fs_if.hready) begin
      if (fx_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL fx_unexpected_issue: got addr 0x%08h expected no transfer", fs_if.haddr);
      end else begin
        e = fx_q.pop_front();
        chk("fx_issue_addr", fs_if.haddr, e.addr);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin : stim
    n_checks = 0;
    n_errors = 0;
    m0_if.htrans = 2'b00; m0_if.haddr = 32'd0; m0_if.hwrite = 1'b0; m0_if.hsize = 3'b010;
    m0_if.hburst = 3'b000; m0_if.hwdata = 32'd0; m0_if.hsel = 1'b0;
    m1_if.htrans = 2'b00; m1_if.haddr = 32'd0; m1_if.hwrite = 1'b0; m1_if.hsize = 3'b010;
    m1_if.hburst = 3'b000; m1_if.hwdata = 32'd0; m1_if.hsel = 1'b0;
    f0_if.htrans = 2'b00; f0_if.haddr = 32'd0; f0_if.hwrite = 1'b0; f0_if.hsize = 3'b010;
    f0_if.hburst = 3'b000; f0_if.hwdata = 32'd0; f0_if.hsel = 1'b0;
    f1_if.htrans = 2'b00; f1_if.haddr = 32'd0; f1_if.hwrite = 1'b0; f1_if.hsize = 3'b010;
    f1_if.hburst = 3'b000; f1_if.hwdata = 32'd0; f1_if.hsel = 1'b0;
    s_if.hready = 1'b1; s_if.hresp = 1'b0; s_if.hrdata = 32'd0;
    fs_if.hready = 1'b1; fs_if.hresp = 1'b0; fs_if.hrdata = 32'd0;

    HRESET = 1'b1;
    tick(); tick();
    HRESET = 1'b0;
    mid();
    chk("reset_htrans", {30'd0, s_if.htrans}, 32'd0);
    chk("reset_hsel", {31'd0, s_if.hsel}, 32'd0);
    chk("reset_m0_hready", {31'd0, m0_if.hready}, 32'd1);
    chk("reset_m1_hready", {31'd0, m1_if.hready}, 32'd1);
    chk("reset_m0_hresp", {31'd0, m0_if.hresp}, 32'd0);
    chk("reset_m1_hresp", {31'd0, m1_if.hresp}, 32'd0);
    tick();

    // Single write from M0 goes straight through.
    drv_m0(2'b10, 32'h100, 1'b1);
    rr_q.push_back('{addr: 32'h100, write: 1'b1});
    mid();
    chk("t1_htrans", {30'd0, s_if.htrans}, 32'd2);
    chk("t1_haddr", s_if.haddr, 32'h100);
    chk("t1_m1_hready_a", {31'd0, m1_if.hready}, 32'd1);
    tick();
    drv_m0(2'b00, 32'd0, 1'b0);
    m0_if.hwdata = 32'hA5A5_A5A5;
    mid();
    chk("t1_hwdata", s_if.hwdata, 32'hA5A5_A5A5);
    chk("t1_m1_hready_d", {31'd0, m1_if.hready}, 32'd1);
    tick();

    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;

    // Simultaneous requests after reset: M0 first, M1 held one cycle.
    drv_m0(2'b10, 32'h0, 1'b0);
    drv_m1(2'b10, 32'h4, 1'b0);
    rr_q.push_back('{addr: 32'h0, write: 1'b0});
    rr_q.push_back('{addr: 32'h4, write: 1'b0});
    mid();
    chk("t2_first_haddr", s_if.haddr, 32'h0);
    chk("t2_m1_hready_a", {31'd0, m1_if.hready}, 32'd1);
    tick();
    drv_m0(2'b00, 32'd0, 1'b0);
    drv_m1(2'b00, 32'd0, 1'b0);
    mid();
    chk("t2_second_htrans", {30'd0, s_if.htrans}, 32'd2);
    chk("t2_second_haddr", s_if.haddr, 32'h4);
    chk("t2_m1_hready_pend", {31'd0, m1_if.hready}, 32'd0);
    tick();
    mid();
    chk("t2_m1_hready_data", {31'd0, m1_if.hready}, 32'd1);
    tick();

    // M0 alone, then a tie: M1 wins because M0 was granted last.
    drv_m0(2'b10, 32'h8, 1'b0);
    rr_q.push_back('{addr: 32'h8, write: 1'b0});
    tick();
    drv_m0(2'b10, 32'hC, 1'b0);
    drv_m1(2'b10, 32'h10, 1'b0);
    rr_q.push_back('{addr: 32'h10, write: 1'b0});
    rr_q.push_back('{addr: 32'hC, write: 1'b0});
    mid();
    chk("t2b_first_haddr", s_if.haddr, 32'h10);
    chk("t2b_m0_hready_a", {31'd0, m0_if.hready}, 32'd1);
    tick();
    drv_m0(2'b00, 32'd0, 1'b0);
    drv_m1(2'b00, 32'd0, 1'b0);
    mid();
    chk("t2b_second_haddr", s_if.haddr, 32'hC);
    chk("t2b_m0_hready_pend", {31'd0, m0_if.hready}, 32'd0);
    tick();
    tick();

    // M0 read with three wait states while M1 presents a write.
    drv_m0(2'b10, 32'h200, 1'b0);
    rr_q.push_back('{addr: 32'h200, write: 1'b0});
    tick();
    drv_m0(2'b00, 32'd0, 1'b0);
    drv_m1(2'b10, 32'h300, 1'b1);
    rr_q.push_back('{addr: 32'h300, write: 1'b1});
    s_if.hready = 1'b0;
    mid();
    chk("t4_w1_haddr", s_if.haddr, 32'h300);
    chk("t4_w1_m0_hready", {31'd0, m0_if.hready}, 32'd0);
    tick();
    drv_m1(2'b00, 32'd0, 1'b0);
    m1_if.hwdata = 32'h1234_5678;
    mid();
    chk("t4_w2_haddr", s_if.haddr, 32'h300);
    chk("t4_w2_htrans", {30'd0, s_if.htrans}, 32'd2);
    chk("t4_w2_m0_hready", {31'd0, m0_if.hready}, 32'd0);
    chk("t4_w2_m1_hready", {31'd0, m1_if.hready}, 32'd0);
    tick();
    mid();
    chk("t4_w3_haddr", s_if.haddr, 32'h300);
    chk("t4_w3_m0_hready", {31'd0, m0_if.hready}, 32'd0);
    tick();
    s_if.hready = 1'b1;
    s_if.hrdata = 32'hDEAD_BEEF;
    mid();
    chk("t4_m0_hready_done", {31'd0, m0_if.hready}, 32'd1);
    chk("t4_m0_hrdata", m0_if.hrdata, 32'hDEAD_BEEF);
    tick();
    s_if.hrdata = 32'd0;
    mid();
    chk("t4_m1_hwdata", s_if.hwdata, 32'h1234_5678);
    chk("t4_m1_hready_data", {31'd0, m1_if.hready}, 32'd1);
    tick();

    // Two-cycle ERROR response routed only to M1.
    drv_m1(2'b10, 32'h400, 1'b0);
    rr_q.push_back('{addr: 32'h400, write: 1'b0});
    tick();
    drv_m1(2'b00, 32'd0, 1'b0);
    s_if.hready = 1'b0;
    s_if.hresp  = 1'b1;
    mid();
    chk("t5_e1_m1_hresp", {31'd0, m1_if.hresp}, 32'd1);
    chk("t5_e1_m1_hready", {31'd0, m1_if.hready}, 32'd0);
    chk("t5_e1_m0_hresp", {31'd0, m0_if.hresp}, 32'd0);
    tick();
    s_if.hready = 1'b1;
    mid();
    chk("t5_e2_m1_hresp", {31'd0, m1_if.hresp}, 32'd1);
    chk("t5_e2_m1_hready", {31'd0, m1_if.hready}, 32'd1);
    chk("t5_e2_m0_hresp", {31'd0, m0_if.hresp}, 32'd0);
    tick();
    s_if.hresp = 1'b0;
    tick();

    // Both masters pending behind a stalled slave, then reset discards them.
    s_if.hready = 1'b0;
    drv_m0(2'b10, 32'h500, 1'b0);
    drv_m1(2'b10, 32'h600, 1'b0);
    tick();
    drv_m0(2'b00, 32'd0, 1'b0);
    drv_m1(2'b00, 32'd0, 1'b0);
    mid();
    chk("t6_m0_hready_pend", {31'd0, m0_if.hready}, 32'd0);
    chk("t6_m1_hready_pend", {31'd0, m1_if.hready}, 32'd0);
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    s_if.hready = 1'b1;
    mid();
    chk("t6_htrans", {30'd0, s_if.htrans}, 32'd0);
    chk("t6_hsel", {31'd0, s_if.hsel}, 32'd0);
    chk("t6_m0_hready", {31'd0, m0_if.hready}, 32'd1);
    chk("t6_m1_hready", {31'd0, m1_if.hready}, 32'd1);
    tick();
    tick();

    // Fixed priority: continuous M0 starves M1 until M0 goes idle.
    drv_f0(2'b10, 32'h1000);
    drv_f1(2'b10, 32'h2000);
    fx_q.push_back('{addr: 32'h1000, write: 1'b0});
    mid();
    chk("t3_f1_hready_a", {31'd0, f1_if.hready}, 32'd1);
    chk("t3_haddr_0", fs_if.haddr, 32'h1000);
    tick();
    drv_f1(2'b00, 32'd0);
    for (int i = 1; i < 4; i++) begin
      drv_f0(2'b10, 32'h1000 + 32'(4 * i));
      fx_q.push_back('{addr: 32'h1000 + 32'(4 * i), write: 1'b0});
      mid();
      chk("t3_f1_hready_starved", {31'd0, f1_if.hready}, 32'd0);
      chk("t3_haddr_m0", fs_if.haddr, 32'h1000 + 32'(4 * i));
      tick();
    end
    drv_f0(2'b00, 32'd0);
    fx_q.push_back('{addr: 32'h2000, write: 1'b0});
    mid();
    chk("t3_haddr_m1", fs_if.haddr, 32'h2000);
    chk("t3_f1_hready_pend", {31'd0, f1_if.hready}, 32'd0);
    tick();
    mid();
    chk("t3_f1_hready_data", {31'd0, f1_if.hready}, 32'd1);
    tick();
    tick();

    chk("rr_queue_empty", 32'(rr_q.size()), 32'd0);
    chk("fx_queue_empty", 32'(fx_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arbiter_2m.md
Name: ahb_lite_arbiter_2m

Overview:
Two-master AHB-Lite arbiter/interconnect that shares the single SDRAM controller slave port. Typical masters are the CPU bus and the HW test master.
- Each master port gets an input-stage holding register, so a losing master is stalled cleanly via its HREADY.
- Transfers are forwarded to the slave as SINGLE/NONSEQ.
- Arbitration is round-robin or fixed priority.

Parameters:
PRIORITY_FIXED, 0, 0 = round-robin between M0/M1; 1 = M0 always wins simultaneous requests.

Ports:
HCLK  input  1  bus clock; all state on rising edge.
HRESET  input  1  synchronous reset, active-high.
M0_HADDR, M1_HADDR  input  32 each  master address.
M0_HTRANS, M1_HTRANS  input  2 each  master transfer type.
M0_HWRITE, M1_HWRITE  input  1 each  master write flag.
M0_HSIZE, M1_HSIZE  input  3 each  master transfer size.
M0_HBURST, M1_HBURST  input  3 each  ignored; only SINGLE/INCR supported.
M0_HWDATA, M1_HWDATA  input  32 each  master write data.
M0_HRDATA, M1_HRDATA  output  32 each  read data, S_HRDATA broadcast.
M0_HREADY, M1_HREADY  output  1 each  per-master ready.
M0_HRESP, M1_HRESP  output  1 each  per-master response.
S_HADDR  output  32  slave address.
S_HTRANS  output  2  IDLE (00) or NONSEQ (10) only.
S_HWRITE  output  1  slave write flag.
S_HSIZE  output  3  slave transfer size.
S_HBURST  output  3  constant 000.
S_HSEL  output  1  equals S_HTRANS[1].
S_HWDATA  output  32  data-phase owner's HWDATA.
S_HRDATA  input  32  slave read data.
S_HREADY  input  1  slave ready.
S_HRESP  input  1  slave response.

Behaviour:
- State:
  - per master: pend_x flag plus held {HADDR, HWRITE, HSIZE}.
  - downer: data-phase owner, NONE/M0/M1.
  - last_grant: 1 bit.
  - lock: 1 bit, plus locked grant.
- Reset (HRESET=1 at edge):
  - pend_0 = pend_1 = 0; downer = NONE; last_grant = M1, so M0 wins the first tie; lock = 0.
  - With no requests: S_HTRANS = 00, S_HSEL = 0, M*_HREADY = 1, M*_HRESP = 0.
  - Reset mid-transfer aborts everything; pending requests are discarded.
- Effective request: req_x = pend_x ? held_x : (M_x_HTRANS[1] & M_x_HREADY). SEQ is treated as a request, same as NONSEQ.
- Grant (combinational):
  - if lock: the locked master;
  - else the only requester;
  - else, with both requesting: M0 if PRIORITY_FIXED, otherwise the master != last_grant.
- Address forwarding:
  - S_HADDR/S_HWRITE/S_HSIZE come from the winner's held registers if pend, else from its live inputs.
  - S_HTRANS = 10 when there is a winner, else 00.
  - Zero-cycle latency on the direct path.
- Lock:
  - Set when NONSEQ is driven while S_HREADY=0; cleared at the first cycle with S_HREADY=1.
  - While set, slave-side address/control stay stable.
- Issue: at each edge with S_HREADY=1 and a winner x:
  - downer <= x; last_grant <= x; pend_x <= 0.
  - With S_HREADY=1 and no winner: downer <= NONE.
  - With S_HREADY=0, downer holds.
- Capture: at an edge where M_x_HTRANS[1]=1, M_x_HREADY=1, and x's live request is not issued that edge: pend_x <= 1 and held_x <= live address/control.
- Master ready:
  - M_x_HREADY = S_HREADY if downer==x;
  - else 0 if pend_x;
  - else 1.
- Master response: M_x_HRESP = S_HRESP if downer==x, else 0. The two-cycle ERROR passes through unchanged.
- Write data: S_HWDATA = HWDATA of downer, 0 when NONE. A pending master holds HWDATA while its HREADY=0, so data is valid when it becomes downer.
- Simultaneous events: a master can have its data phase completing and its next request captured on the same edge. On the next cycle it is not downer, has pend=1, and sees HREADY=0.
- Ordering: at most one pending transfer per master. Per-master program order is preserved. No transfer is dropped or duplicated.

Test Plan:
1. Reset, then M0 single write to 0x100, data 0xA5A5A5A5, S_HREADY=1 → S_HTRANS=10 and S_HADDR=0x100 the same cycle; S_HWDATA=0xA5A5A5A5 next cycle; M1_HREADY stays 1.
2. Both request in the same cycle (M0 0x0, M1 0x4), round-robin → M0 issued first. M1_HREADY=0 for one cycle while it is pending. M1 issued on the next edge. Repeat the pair: M1 wins, since last_grant=M0.
3. PRIORITY_FIXED=1 and M0 requests every cycle → M1 never issued while M0 is continuous; M1 issued within 1 cycle once M0 goes IDLE.
4. Slave inserts 3 wait states on an M0 read while M1 presents NONSEQ → S_HADDR stable over the whole wait. M0_HRDATA is valid when M0_HREADY returns to 1. M1 is captured and issued on the first S_HREADY=1 edge.
5. Slave returns ERROR to M1 → M1_HRESP=1 for both cycles; M0_HRESP stays 0.
6. Assert HRESET with both masters pending → next cycle S_HTRANS=00, pend cleared, both M*_HREADY=1.
